// File: rtl/dmem_arb.sv
// dmem_arb: round-robin arbiter letting two CPUs share one line-wide d_mem port.
// Define DMEM_ARB_TIMEOUT_EN to add an ACCESS watchdog that completes with a poison line and sets err.
module dmem_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] cpu0_u_addr,
  input  logic        cpu0_u_re,
  input  logic        cpu0_u_we,
  input  logic [63:0] cpu0_d_line,
  input  logic [10:0] cpu1_u_addr,
  input  logic        cpu1_u_re,
  input  logic        cpu1_u_we,
  input  logic [63:0] cpu1_d_line,
  output logic        cpu0_u_rdy,
  output logic        cpu1_u_rdy,
  output logic [63:0] u_rd_data,
  output logic [10:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rd_data,
  input  logic        mem_rdy,
  output logic        owner,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [63:0] POISON_LINE = 64'hDEAD_DEAD_DEAD_DEAD;

  state_t state, state_nxt;
  logic   last_owner;
  logic   req0, req1;
  logic   grant_valid, grant_id, grant_we;
  logic   timed_out;

  assign req0        = cpu0_u_re | cpu0_u_we;
  assign req1        = cpu1_u_re | cpu1_u_we;
  assign grant_valid = req0 | req1;
  // On a tie the CPU that was not served last wins; otherwise the lone requester.
  assign grant_id    = (req0 && req1) ? ~last_owner : ~req0;
  assign grant_we    = grant_id ? cpu1_u_we : cpu0_u_we;
  assign busy        = (state != IDLE);

`ifdef DMEM_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  assign timed_out = (state == ACCESS) && !mem_rdy && (tmo_cnt == 8'd254);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && grant_valid)
        tmo_cnt <= 8'd0;
      else if (state == ACCESS && !mem_rdy)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (timed_out)
        err_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cpu0_u_rdy = 1'b0;
    cpu1_u_rdy = 1'b0;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ACCESS;
      ACCESS:  if (mem_rdy || timed_out) state_nxt = RESP;
      RESP: begin
        state_nxt  = IDLE;
        cpu0_u_rdy = ~owner;
        cpu1_u_rdy = owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction fields are captured once at grant so the memory side never sees requester churn.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= 1'b1;
      owner      <= 1'b0;
      mem_addr   <= 11'd0;
      mem_wdata  <= 64'd0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      u_rd_data  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_id;
            mem_addr  <= grant_id ? cpu1_u_addr : cpu0_u_addr;
            mem_wdata <= grant_id ? cpu1_d_line : cpu0_d_line;
            mem_we    <= grant_we;
            mem_re    <= ~grant_we;
          end
        end
        ACCESS: begin
          if (timed_out) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            u_rd_data <= POISON_LINE;
          end else if (mem_rdy) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (mem_re)
              u_rd_data <= mem_rd_data;
          end
        end
        RESP:    last_owner <= owner;
        default: ;
      endcase
    end
  end

endmodule
